// File: rtl/delivery_core_n_pkg.sv
// delivery_core_n_pkg: shared state encoding, display codes and sizing helper
package delivery_core_n_pkg;
  localparam logic [3:0] SSD_IDLE     = 4'h0;
  localparam logic [3:0] SSD_OUTBOUND = 4'h1;
  localparam logic [3:0] SSD_ARRIVE   = 4'h2;
  localparam logic [3:0] SSD_WAIT     = 4'h3;
  localparam logic [3:0] SSD_UTURN_O  = 4'h4;
  localparam logic [3:0] SSD_HOME     = 4'h5;
  localparam logic [3:0] SSD_UTURN_H  = 4'h6;
  localparam logic [3:0] SSD_NOCOLOR  = 4'hE;
  localparam logic [3:0] SSD_END      = 4'hF;
  // State codes equal the display codes so the display register is a copy of the next state.
  typedef enum logic [3:0] {
    S_IDLE         = SSD_IDLE,
    S_OUTBOUND     = SSD_OUTBOUND,
    S_ARRIVE_BUZZ  = SSD_ARRIVE,
    S_WAIT_RETURN  = SSD_WAIT,
    S_UTURN_OUT    = SSD_UTURN_O,
    S_HOMEBOUND    = SSD_HOME,
    S_UTURN_HOME   = SSD_UTURN_H,
    S_NOCOLOR_BUZZ = SSD_NOCOLOR,
    S_END_BUZZ     = SSD_END
  } state_e;
  function automatic int cnt_bits(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/delivery_core_n_edge_debounce.sv
// delivery_core_n_edge_debounce: 2-flop sync, DB-cycle debounce, one-cycle rising-edge pulse
//   clk, rst (sync, active-low) ; sig_i raw async input ; rise_o pulse on debounced rise
module delivery_core_n_edge_debounce
  import delivery_core_n_pkg::*;
#(
  parameter int DB = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic rise_o
);
  localparam int CW = cnt_bits(DB);
  logic [1:0]    sync_q;
  logic          level_q, level_d, rise_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          differ, accept;
  assign differ = sync_q[1] != level_q;
  assign accept = differ && cnt_q == CW'(DB - 1);
  always_comb begin
    cnt_d   = (differ && !accept) ? cnt_q + 1'b1 : '0;
    level_d = accept ? sync_q[1] : level_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], sig_i};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= level_d & ~level_q;
    end
  end
  assign rise_o = rise_q;
endmodule

// File: rtl/delivery_core_n.sv
// delivery_core_n: delivery cart sequencer (start, outbound, drop, return, U-turns, homebound)
//   clk, rst (sync, active-low) ; hall_i raw magnet ; object_color_i / station_color_i colour codes
//   end_of_track_i, multi_drop_i, uturn_finished_i, buzz_finished_i ; en_tracking_o, en_uturn_o,
//   en_buzz_o, ssd_code_o, station_count_o (saturating), fault_o (sticky until next start)
module delivery_core_n
  import delivery_core_n_pkg::*;
#(
  parameter int COLOR_W = 2,
  parameter int HALL_DB = 4,
  parameter int TIMEOUT = 1000,
  parameter int CNT_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hall_i,
  input  logic [COLOR_W-1:0] object_color_i,
  input  logic [COLOR_W-1:0] station_color_i,
  input  logic               end_of_track_i,
  input  logic               multi_drop_i,
  input  logic               uturn_finished_i,
  input  logic               buzz_finished_i,
  output logic               en_tracking_o,
  output logic               en_uturn_o,
  output logic               en_buzz_o,
  output logic [3:0]         ssd_code_o,
  output logic [CNT_W-1:0]   station_count_o,
  output logic               fault_o
);
  localparam int TW = $clog2(TIMEOUT + 1);
  state_e             state_q, state_d;
  logic [COLOR_W-1:0] color_q, color_d, st_q, st_prev_q;
  logic               multi_q, multi_d, fault_q, fault_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]      tmo_q, tmo_d;
  logic               start, match, expired, tracking;
  logic               en_t_q, en_u_q, en_b_q;
  logic [3:0]         ssd_q;
  delivery_core_n_edge_debounce #(.DB(HALL_DB)) u_hall (
    .clk   (clk),
    .rst   (rst),
    .sig_i (hall_i),
    .rise_o(start)
  );
  // A station is seen once, on the registered 0 -> nonzero step.
  assign match    = st_q != '0 && st_prev_q == '0 && st_q == color_q;
  assign expired  = tmo_q == TW'(TIMEOUT - 1);
  assign tracking = state_d == S_OUTBOUND || state_d == S_HOMEBOUND;
  always_comb begin
    state_d = state_q;
    color_d = color_q;
    multi_d = multi_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    case (state_q)
      S_IDLE: if (start) begin
        if (object_color_i == '0) state_d = S_NOCOLOR_BUZZ;
        else begin
          state_d = S_OUTBOUND;
          color_d = object_color_i;
          multi_d = multi_drop_i;
          cnt_d   = '0;
          fault_d = 1'b0;
        end
      end
      S_NOCOLOR_BUZZ: if (buzz_finished_i) state_d = S_IDLE;
      S_OUTBOUND: begin
        if (match) begin
          state_d = S_ARRIVE_BUZZ;
          cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        end else if (end_of_track_i || expired) begin
          state_d = S_END_BUZZ;
          fault_d = cnt_q == '0 || expired;
        end
      end
      S_ARRIVE_BUZZ: if (buzz_finished_i) state_d = multi_q ? S_OUTBOUND : S_WAIT_RETURN;
      S_WAIT_RETURN: if (start) state_d = S_UTURN_OUT;
      S_END_BUZZ:    if (buzz_finished_i) state_d = S_UTURN_OUT;
      S_UTURN_OUT:   if (uturn_finished_i) state_d = S_HOMEBOUND;
      S_HOMEBOUND: if (end_of_track_i || expired) begin
        state_d = S_UTURN_HOME;
        fault_d = fault_q | expired;
      end
      S_UTURN_HOME:  if (uturn_finished_i) state_d = S_IDLE;
      default:       state_d = S_IDLE;
    endcase
    // Restart on every entry (including ARRIVE_BUZZ -> OUTBOUND), hold 0 outside tracking.
    tmo_d = (tracking && state_d == state_q) ? tmo_q + 1'b1 : '0;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      color_q   <= '0;
      multi_q   <= 1'b0;
      cnt_q     <= '0;
      fault_q   <= 1'b0;
      tmo_q     <= '0;
      st_q      <= '0;
      st_prev_q <= '0;
      en_t_q    <= 1'b0;
      en_u_q    <= 1'b0;
      en_b_q    <= 1'b0;
      ssd_q     <= '0;
    end else begin
      state_q   <= state_d;
      color_q   <= color_d;
      multi_q   <= multi_d;
      cnt_q     <= cnt_d;
      fault_q   <= fault_d;
      tmo_q     <= tmo_d;
      st_q      <= station_color_i;
      st_prev_q <= st_q;
      en_t_q    <= tracking;
      en_u_q    <= state_d == S_UTURN_OUT || state_d == S_UTURN_HOME;
      en_b_q    <= state_d == S_ARRIVE_BUZZ || state_d == S_END_BUZZ || state_d == S_NOCOLOR_BUZZ;
      ssd_q     <= state_d;
    end
  end
  assign en_tracking_o   = en_t_q;
  assign en_uturn_o      = en_u_q;
  assign en_buzz_o       = en_b_q;
  assign ssd_code_o      = ssd_q;
  assign station_count_o = cnt_q;
  assign fault_o         = fault_q;
endmodule

// File: tb/tb_delivery_core_n.sv
// tb_delivery_core_n: trip-level reference model feeding a scoreboard checked on every output change
module tb_delivery_core_n;
  localparam int HALL_DB = 4;
  localparam int TIMEOUT = 20;
  localparam int CNT_W   = 2;
  typedef struct packed {
    logic [3:0]       ssd;
    logic             t, u, b;
    logic [CNT_W-1:0] cnt;
    logic             flt;
  } snap_t;
  logic clk = 0, rst = 0, hall = 0, eot = 0, multi_drop = 0, uturn_fin = 0, buzz_fin = 0;
  logic [1:0] object_color = 0, station_color = 0;
  logic en_tracking, en_uturn, en_buzz, fault;
  logic [3:0] ssd_code;
  logic [CNT_W-1:0] station_count;
  int vectors = 0, miscompares = 0, dwell = 0, last_dwell = 0;
  bit mon_en = 0;
  snap_t exp_q[$];
  snap_t prev, cur;
  logic [CNT_W-1:0] m_cnt = 0;
  logic m_flt = 0;
  logic [1:0] st_list[$];
  delivery_core_n #(.COLOR_W(2), .HALL_DB(HALL_DB), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .hall_i(hall), .object_color_i(object_color),
    .station_color_i(station_color), .end_of_track_i(eot), .multi_drop_i(multi_drop),
    .uturn_finished_i(uturn_fin), .buzz_finished_i(buzz_fin), .en_tracking_o(en_tracking),
    .en_uturn_o(en_uturn), .en_buzz_o(en_buzz), .ssd_code_o(ssd_code),
    .station_count_o(station_count), .fault_o(fault)
  );
  always #5 clk = ~clk;
  // Enables by display code: tracking in 1/5, U-turn in 4/6, buzzer in 2/E/F.
  function automatic snap_t mk(input logic [3:0] s, input logic [CNT_W-1:0] c, input logic f);
    mk.ssd = s;
    mk.t   = s == 4'h1 || s == 4'h5;
    mk.u   = s == 4'h4 || s == 4'h6;
    mk.b   = s == 4'h2 || s == 4'hE || s == 4'hF;
    mk.cnt = c;
    mk.flt = f;
  endfunction
  always @(negedge clk) begin
    if (mon_en) begin
      cur = {ssd_code, en_tracking, en_uturn, en_buzz, station_count, fault};
      if (cur !== prev) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_change got=%h", cur);
        end else begin
          snap_t e;
          e = exp_q.pop_front();
          if (cur !== e) begin
            miscompares++;
            $display("FAIL transition got=%h exp=%h", cur, e);
          end
        end
        last_dwell = dwell;
        dwell = 1;
        prev = cur;
      end else dwell++;
    end
  end
  task automatic push(input logic [3:0] s);
    exp_q.push_back(mk(s, m_cnt, m_flt));
  endtask
  task automatic wait_ssd(input logic [3:0] s);
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (ssd_code === s) return;
    end
    vectors++;
    miscompares++;
    $display("FAIL wait_ssd got=%h exp=%h", ssd_code, s);
  endtask
  task automatic check_dwell();
    #1;
    vectors++;
    if (last_dwell != TIMEOUT) begin
      miscompares++;
      $display("FAIL timeout_dwell got=%0d exp=%0d", last_dwell, TIMEOUT);
    end
  endtask
  task automatic pulse_buzz();
    buzz_fin = 1;
    repeat ($urandom_range(1, 3)) @(negedge clk);
    buzz_fin = 0;
  endtask
  task automatic pulse_uturn();
    uturn_fin = 1;
    repeat ($urandom_range(1, 3)) @(negedge clk);
    uturn_fin = 0;
  endtask
  task automatic hall_press();
    hall = 1;
    repeat ($urandom_range(HALL_DB, HALL_DB + 2)) @(negedge clk);
    hall = 0;
  endtask
  task automatic hall_glitch();
    hall = 1;
    repeat ($urandom_range(1, HALL_DB - 1)) @(negedge clk);
    hall = 0;
    repeat (HALL_DB + 2) @(negedge clk);
  endtask
  task automatic present(input logic [1:0] c);
    station_color = c;
    @(negedge clk);
    station_color = 0;
    @(negedge clk);
  endtask
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction
  task automatic trip(input logic [1:0] col, input bit multi, input bit tmo_out, input bit tmo_home,
                      input bit simul, input bit glitch, input bit ign);
    bit waiting;
    repeat (HALL_DB + 4) @(negedge clk);
    object_color = col;
    multi_drop = multi;
    if (glitch) hall_glitch();
    if (col == 0) begin
      push(4'hE); hall_press(); wait_ssd(4'hE);
      push(4'h0); pulse_buzz(); wait_ssd(4'h0);
      return;
    end
    m_cnt = 0; m_flt = 0;
    push(4'h1); hall_press(); wait_ssd(4'h1);
    object_color = 2'($urandom);
    multi_drop = 1'($urandom);
    waiting = 0;
    for (int i = 0; i < st_list.size() && !waiting; i++) begin
      if (st_list[i] == col) begin
        m_cnt = sat_inc(m_cnt);
        push(4'h2);
        present(st_list[i]);
        wait_ssd(4'h2);
        if (ign) begin
          hall_press();
          repeat (HALL_DB + 4) @(negedge clk);
        end
        push(multi ? 4'h1 : 4'h3); pulse_buzz(); wait_ssd(multi ? 4'h1 : 4'h3);
        waiting = !multi;
      end else present(st_list[i]);
    end
    if (!waiting && simul) begin
      m_cnt = sat_inc(m_cnt);
      push(4'h2);
      station_color = col;
      @(negedge clk);
      station_color = 0;
      eot = 1;
      wait_ssd(4'h2);
      eot = 0;
      push(4'h3); pulse_buzz(); wait_ssd(4'h3);
      waiting = 1;
    end
    if (waiting) begin
      if (glitch) hall_glitch();
      push(4'h4); hall_press(); wait_ssd(4'h4);
    end else begin
      if (tmo_out) begin
        m_flt = 1; push(4'hF); wait_ssd(4'hF); check_dwell();
      end else begin
        m_flt = m_cnt == 0; push(4'hF); eot = 1; wait_ssd(4'hF); eot = 0;
      end
      push(4'h4); pulse_buzz(); wait_ssd(4'h4);
    end
    push(4'h5); pulse_uturn(); wait_ssd(4'h5);
    present(col);
    if (tmo_home) begin
      m_flt = 1; push(4'h6); wait_ssd(4'h6); check_dwell();
    end else begin
      push(4'h6); eot = 1; wait_ssd(4'h6); eot = 0;
    end
    push(4'h0); pulse_uturn(); wait_ssd(4'h0);
  endtask
  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
  initial begin
    repeat (3) @(negedge clk);
    vectors++;
    cur = {ssd_code, en_tracking, en_uturn, en_buzz, station_count, fault};
    if (cur !== mk(4'h0, 0, 0)) begin
      miscompares++;
      $display("FAIL reset_state got=%h exp=%h", cur, mk(4'h0, 0, 0));
    end
    rst = 1;
    prev = mk(4'h0, 0, 0);
    mon_en = 1;
    st_list = {};                trip(2'd0, 0, 0, 0, 0, 1, 0);
    st_list = '{2'd3, 2'd1};     trip(2'd1, 0, 0, 0, 0, 1, 1);
    st_list = '{2'd2, 2'd1, 2'd2}; trip(2'd2, 1, 0, 0, 0, 0, 0);
    st_list = '{2'd1, 2'd3};     trip(2'd2, 0, 0, 0, 0, 0, 0);
    st_list = {};                trip(2'd1, 0, 0, 0, 1, 0, 0);
    st_list = {};                trip(2'd3, 0, 1, 0, 0, 0, 0);
    st_list = '{2'd1};           trip(2'd1, 0, 0, 1, 0, 0, 0);
    st_list = '{2'd3, 2'd3, 2'd3, 2'd3}; trip(2'd3, 1, 0, 0, 0, 0, 0);
    st_list = '{2'd2};           trip(2'd2, 1, 1, 0, 0, 0, 0);
    // Reset in the middle of a multi-drop trip with one station already counted.
    repeat (HALL_DB + 4) @(negedge clk);
    object_color = 1; multi_drop = 1; m_cnt = 0; m_flt = 0;
    push(4'h1); hall_press(); wait_ssd(4'h1);
    m_cnt = 1; push(4'h2); present(2'd1); wait_ssd(4'h2);
    push(4'h1); pulse_buzz(); wait_ssd(4'h1);
    m_cnt = 0; m_flt = 0; push(4'h0);
    rst = 0;
    repeat (3) @(negedge clk);
    vectors++;
    cur = {ssd_code, en_tracking, en_uturn, en_buzz, station_count, fault};
    if (cur !== mk(4'h0, 0, 0)) begin
      miscompares++;
      $display("FAIL mid_reset got=%h exp=%h", cur, mk(4'h0, 0, 0));
    end
    rst = 1;
    for (int k = 0; k < 40; k++) begin
      logic [1:0] col;
      bit multi;
      col = 2'($urandom);
      multi = 1'($urandom);
      st_list = {};
      repeat ($urandom_range(0, 4)) st_list.push_back(2'($urandom_range(1, 3)));
      trip(col, multi, $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0,
           !multi && $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
    end
    repeat (10) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL leftover_expect got=%0d exp=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
